// File: rtl/dct_1d_mac_engine.sv
// Time-multiplexed N-point 1-D DCT/IDCT engine: LANES shared MAC units sweep an NxN
// coefficient matrix (forward or transposed), then round half-up and saturate each output.
module dct_1d_mac_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N          = 8,
  parameter int unsigned LANES      = 1,
  parameter int unsigned FRAC_BITS  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         inverse,
  input  logic [DATA_WIDTH*N-1:0]      data_in,
  input  logic [DATA_WIDTH*N*N-1:0]    coeff_vector,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH*N-1:0]      dct_out,
  output logic                         busy
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned AW = 2 * DW + CW;
  localparam int unsigned GN = N / LANES;
  localparam int unsigned GW = (GN > 1) ? $clog2(GN) : 1;
  localparam int unsigned IW = $clog2(N * N);

  // One bit of headroom above the accumulator so the rounding add cannot wrap.
  localparam logic signed [AW:0] Rnd  = ((AW + 1)'(1) << FRAC_BITS) >> 1;
  localparam logic signed [AW:0] MaxV = {{(AW - DW + 2){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [AW:0] MinV = {{(AW - DW + 2){1'b1}}, {(DW - 1){1'b0}}};

  if (N < 2 || (N % LANES) != 0) begin : g_param_err
    $error("dct_1d_mac_engine: N must be >= 2 and a multiple of LANES");
  end

  typedef enum logic [1:0] {StIdle, StCompute, StOutput} state_e;

  state_e                  state_q;
  logic                    out_valid_q;
  logic                    inverse_q;
  logic [GW-1:0]           grp_q;
  logic [CW-1:0]           col_q;
  logic signed [DW-1:0]    data_q [N];
  logic signed [DW-1:0]    coef_q [N*N];
  logic signed [DW-1:0]    out_q  [N];
  logic signed [AW-1:0]    acc_q  [LANES];

  logic [CW-1:0]           row    [LANES];
  logic [IW-1:0]           idx    [LANES];
  logic signed [2*DW-1:0]  prod   [LANES];
  logic signed [AW-1:0]    sum    [LANES];
  logic signed [AW:0]      shf    [LANES];
  logic signed [DW-1:0]    res    [LANES];
  logic                    col_last;
  logic                    grp_last;

  assign col_last = (col_q == CW'(N - 1));
  assign grp_last = (grp_q == GW'(GN - 1));

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      row[l]  = CW'(32'(grp_q) * LANES + 32'(l));
      // Inverse mode walks the matrix column-wise, i.e. uses C transposed.
      idx[l]  = inverse_q ? IW'(32'(col_q) * N + 32'(row[l]))
                          : IW'(32'(row[l]) * N + 32'(col_q));
      prod[l] = (2 * DW)'(coef_q[idx[l]]) * (2 * DW)'(data_q[col_q]);
      sum[l]  = acc_q[l] + AW'(prod[l]);
      shf[l]  = ((AW + 1)'(sum[l]) + Rnd) >>> FRAC_BITS;
      if (shf[l] > MaxV) begin
        res[l] = MaxV[DW-1:0];
      end else if (shf[l] < MinV) begin
        res[l] = MinV[DW-1:0];
      end else begin
        res[l] = shf[l][DW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      inverse_q   <= 1'b0;
      grp_q       <= '0;
      col_q       <= '0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
      for (int i = 0; i < N; i++) out_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++) data_q[i] <= data_in[i*DW +: DW];
            for (int i = 0; i < N * N; i++) coef_q[i] <= coeff_vector[i*DW +: DW];
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
            inverse_q <= inverse;
            grp_q     <= '0;
            col_q     <= '0;
            state_q   <= StCompute;
          end
        end
        StCompute: begin
          for (int l = 0; l < LANES; l++) begin
            if (col_last) begin
              out_q[row[l]] <= res[l];
              acc_q[l]      <= '0;
            end else begin
              acc_q[l] <= sum[l];
            end
          end
          if (col_last) begin
            col_q <= '0;
            if (grp_last) begin
              grp_q       <= '0;
              state_q     <= StOutput;
              out_valid_q <= 1'b1;
            end else begin
              grp_q <= grp_q + GW'(1);
            end
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
        StOutput: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) dct_out[i*DW +: DW] = out_q[i];
  end

  assign out_valid = out_valid_q;
  assign busy      = (state_q != StIdle);
  assign in_ready  = (state_q == StIdle) && !reset;

endmodule
